// File: rtl/cbus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_arb_pkg
//  Purpose  : Shared types and constants for the core-bus round-robin arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package cbus_arb_pkg;

    localparam int CBUS_MASTER_NUM      = 4;
    localparam int CBUS_ARB_TIMEOUT_DEF = 255;
    localparam int CORE_UID_W           = 2;
    localparam int CBUS_ARB_ST_W        = 1;

    typedef logic [CORE_UID_W-1:0] CoreUidBus;

    typedef enum logic [CBUS_ARB_ST_W-1:0] {
        CBUS_ARB_ST_IDLE = 1'b0,
        CBUS_ARB_ST_BUSY = 1'b1
    } cbus_arb_st_e;

    function automatic logic [CBUS_MASTER_NUM-1:0] uid2onehot(input CoreUidBus uid);
        logic [CBUS_MASTER_NUM-1:0] oh;
        oh      = '0;
        oh[uid] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_arb_if
//  Purpose  : Request/grant bundle between the bus masters and the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface cbus_arb_if;
    import cbus_arb_pkg::*;

    logic      m0_req;
    logic      m1_req;
    logic      m2_req;
    logic      m3_req;
    logic      m_ack;
    logic      m0_grnt;
    logic      m1_grnt;
    logic      m2_grnt;
    logic      m3_grnt;
    logic      arb_busy;
    CoreUidBus arb_owner;
    logic      arb_timeout;
    CoreUidBus arb_timeout_uid;

    // Requesting side: drives requests and the slave accept, observes grants.
    modport master (
        output m0_req, m1_req, m2_req, m3_req, m_ack,
        input  m0_grnt, m1_grnt, m2_grnt, m3_grnt,
        input  arb_busy, arb_owner, arb_timeout, arb_timeout_uid
    );

    // Arbiter side.
    modport slave (
        input  m0_req, m1_req, m2_req, m3_req, m_ack,
        output m0_grnt, m1_grnt, m2_grnt, m3_grnt,
        output arb_busy, arb_owner, arb_timeout, arb_timeout_uid
    );

endinterface
`default_nettype wire

// File: rtl/cbus_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_arb_rr_pick
//  Purpose  : Combinational round-robin selector starting after i_ptr.
//  Revision : 1.0  initial release
// ============================================================================
module cbus_arb_rr_pick
    import cbus_arb_pkg::*;
(
    input  wire logic [CBUS_MASTER_NUM-1:0] i_req,
    input  wire logic [CBUS_MASTER_NUM-1:0] i_mask,
    input  wire CoreUidBus                  i_ptr,
    output logic                            o_valid,
    output CoreUidBus                       o_uid
);

    logic [CBUS_MASTER_NUM-1:0] w_elig;
    CoreUidBus                  w_cand;

    // Walk offsets from farthest to nearest so the nearest eligible uid wins.
    always_comb begin
        w_elig  = i_req & ~i_mask;
        w_cand  = i_ptr;
        o_valid = 1'b0;
        o_uid   = '0;
        for (int k = CBUS_MASTER_NUM; k >= 1; k--) begin
            w_cand = i_ptr + CoreUidBus'(k);
            if (w_elig[w_cand]) begin
                o_valid = 1'b1;
                o_uid   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cbus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_arb
//  Purpose  : 4-master round-robin core-bus arbiter with zero-bubble handoff.
//             Optional watchdog release enabled by CBUS_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cbus_arb
    import cbus_arb_pkg::*;
#(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = CBUS_ARB_TIMEOUT_DEF
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cbus_arb_if.slave   bus
);

    cbus_arb_st_e               r_state;
    cbus_arb_st_e               w_state_nxt;
    CoreUidBus                  r_owner;
    CoreUidBus                  w_owner_nxt;
    CoreUidBus                  r_ptr;
    CoreUidBus                  w_ptr_nxt;
    logic [CBUS_MASTER_NUM-1:0] r_grnt;
    logic [CBUS_MASTER_NUM-1:0] w_grnt_nxt;

    logic [CBUS_MASTER_NUM-1:0] w_req;
    logic                       w_busy;
    logic                       w_owner_req;
    logic                       w_wd_expire;
    logic                       w_release;
    CoreUidBus                  w_pick_ptr;
    logic [CBUS_MASTER_NUM-1:0] w_pick_mask;
    logic                       w_pick_valid;
    CoreUidBus                  w_pick_uid;

    assign w_req       = {bus.m3_req, bus.m2_req, bus.m1_req, bus.m0_req};
    assign w_busy      = (r_state == CBUS_ARB_ST_BUSY);
    assign w_owner_req = w_req[r_owner];
    assign w_release   = w_busy & ((bus.m_ack & w_owner_req) | ~w_owner_req | w_wd_expire);

    // While busy, the owner becomes the pointer and is masked so it ranks last.
    assign w_pick_ptr  = w_busy ? r_owner : r_ptr;
    assign w_pick_mask = w_busy ? uid2onehot(r_owner) : '0;

    cbus_arb_rr_pick u_pick (
        .i_req   (w_req),
        .i_mask  (w_pick_mask),
        .i_ptr   (w_pick_ptr),
        .o_valid (w_pick_valid),
        .o_uid   (w_pick_uid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CBUS_ARB_ST_IDLE;
            r_owner <= '0;
            r_ptr   <= CoreUidBus'(CBUS_MASTER_NUM - 1);
            r_grnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grnt  <= w_grnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grnt_nxt  = r_grnt;
        case (r_state)
            CBUS_ARB_ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = CBUS_ARB_ST_BUSY;
                    w_owner_nxt = w_pick_uid;
                    w_grnt_nxt  = uid2onehot(w_pick_uid);
                end
            end
            CBUS_ARB_ST_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt = r_owner;
                    if (w_pick_valid) begin
                        w_owner_nxt = w_pick_uid;
                        w_grnt_nxt  = uid2onehot(w_pick_uid);
                    end else begin
                        w_state_nxt = CBUS_ARB_ST_IDLE;
                        w_owner_nxt = '0;
                        w_grnt_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = CBUS_ARB_ST_IDLE;
                w_owner_nxt = '0;
                w_grnt_nxt  = '0;
            end
        endcase
    end

`ifdef CBUS_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] c_TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_wd_cnt;
    logic                 r_timeout;
    CoreUidBus            r_timeout_uid;
    logic                 w_tmo_fire;

    // Counter value c_TMO_LAST marks the TIMEOUT_CYCLES-th busy cycle without accept.
    assign w_wd_expire = w_busy & (r_wd_cnt == c_TMO_LAST);
    assign w_tmo_fire  = w_wd_expire & w_owner_req & ~bus.m_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_timeout     <= 1'b0;
            r_timeout_uid <= '0;
        end else begin
            if (!w_busy || w_release || bus.m_ack) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            r_timeout     <= w_tmo_fire;
            r_timeout_uid <= w_tmo_fire ? r_owner : '0;
        end
    end

    assign bus.arb_timeout     = r_timeout;
    assign bus.arb_timeout_uid = r_timeout_uid;
`else
    logic [TIMEOUT_W-1:0] w_unused_tmo;

    assign w_unused_tmo        = TIMEOUT_W'(TIMEOUT_CYCLES);
    assign w_wd_expire         = 1'b0;
    assign bus.arb_timeout     = 1'b0;
    assign bus.arb_timeout_uid = '0;
`endif

    assign bus.m0_grnt   = r_grnt[0];
    assign bus.m1_grnt   = r_grnt[1];
    assign bus.m2_grnt   = r_grnt[2];
    assign bus.m3_grnt   = r_grnt[3];
    assign bus.arb_busy  = w_busy;
    assign bus.arb_owner = r_owner;

endmodule
`default_nettype wire
